issue_alu_pipe_buffer: RTL and testbench

- Parametrised successor to the single-stage issue-to-ALU pipeline register.
- Sits between the issue stage and one ALU (SALU or SIMD).
- Replaces the unconditional select-enabled flop stage with a DEPTH-entry in-order buffer.
- Adds a valid/ready handshake, so ALU backpressure no longer drops instructions.
- Adds per-wavefront flush, so a halted or branched wavefront's queued instructions are squashed before execution.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/issue_alu_pipe_buffer_if.sv | 55 +++++
 rtl/issue_buf_entry.sv | 37 +++
 rtl/issue_alu_pipe_buffer.sv | 115 +++++++++++
 tb/tb_issue_alu_pipe_buffer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the issue-to-ALU buffer: field widths, the packed
// instruction bundle carried through each entry, and the flush compare helper.
package alu_pkg;

   localparam int WFID_W = 6;
   localparam int PC_W   = 32;
   localparam int OPC_W  = 32;
   localparam int IMM0_W = 16;
   localparam int IMM1_W = 32;
   localparam int ADDR_W = 12;

   typedef struct packed {
      logic [WFID_W-1:0] wfid;
      logic [PC_W-1:0]   instr_pc;
      logic [OPC_W-1:0]  opcode;
      logic [IMM0_W-1:0] imm_value0;
      logic [IMM1_W-1:0] imm_value1;
      logic [ADDR_W-1:0] source1_addr;
      logic [ADDR_W-1:0] source2_addr;
      logic [ADDR_W-1:0] source3_addr;
      logic [ADDR_W-1:0] dest1_addr;
      logic [ADDR_W-1:0] dest2_addr;
   } alu_issue_t;

   localparam int ENTRY_W = $bits(alu_issue_t);

   // True when a flush request targets the given wavefront.
   function automatic logic wfid_match(input logic flush_valid,
                                       input logic [WFID_W-1:0] flush_wfid,
                                       input logic [WFID_W-1:0] wfid);
      return flush_valid && (flush_wfid == wfid);
   endfunction

endpackage

// File: rtl/issue_alu_pipe_buffer_if.sv
// Issue-side, ALU-side and flush signals of the issue-to-ALU buffer.
// slave is the buffer's view; master is the view of whatever drives it.
interface issue_alu_pipe_buffer_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WFID_W-1:0] in_wfid;
   logic [PC_W-1:0]   in_instr_pc;
   logic [OPC_W-1:0]  in_opcode;
   logic [IMM0_W-1:0] in_imm_value0;
   logic [IMM1_W-1:0] in_imm_value1;
   logic [ADDR_W-1:0] in_source1_addr;
   logic [ADDR_W-1:0] in_source2_addr;
   logic [ADDR_W-1:0] in_source3_addr;
   logic [ADDR_W-1:0] in_dest1_addr;
   logic [ADDR_W-1:0] in_dest2_addr;

   logic              out_valid;
   logic              out_ready;
   logic [WFID_W-1:0] out_wfid;
   logic [PC_W-1:0]   out_instr_pc;
   logic [OPC_W-1:0]  out_opcode;
   logic [IMM0_W-1:0] out_imm_value0;
   logic [IMM1_W-1:0] out_imm_value1;
   logic [ADDR_W-1:0] out_source1_addr;
   logic [ADDR_W-1:0] out_source2_addr;
   logic [ADDR_W-1:0] out_source3_addr;
   logic [ADDR_W-1:0] out_dest1_addr;
   logic [ADDR_W-1:0] out_dest2_addr;

   logic              flush_valid;
   logic [WFID_W-1:0] flush_wfid;

   modport slave (
      input  in_valid, in_wfid, in_instr_pc, in_opcode, in_imm_value0, in_imm_value1,
             in_source1_addr, in_source2_addr, in_source3_addr, in_dest1_addr, in_dest2_addr,
      output in_ready,
      output out_valid, out_wfid, out_instr_pc, out_opcode, out_imm_value0, out_imm_value1,
             out_source1_addr, out_source2_addr, out_source3_addr, out_dest1_addr, out_dest2_addr,
      input  out_ready,
      input  flush_valid, flush_wfid
   );

   modport master (
      output in_valid, in_wfid, in_instr_pc, in_opcode, in_imm_value0, in_imm_value1,
             in_source1_addr, in_source2_addr, in_source3_addr, in_dest1_addr, in_dest2_addr,
      input  in_ready,
      input  out_valid, out_wfid, out_instr_pc, out_opcode, out_imm_value0, out_imm_value1,
             out_source1_addr, out_source2_addr, out_source3_addr, out_dest1_addr, out_dest2_addr,
      output out_ready,
      output flush_valid, flush_wfid
   );

endinterface

// File: rtl/issue_buf_entry.sv
// One storage slot of the issue buffer: an instruction bundle plus a live bit
// that a matching flush clears while the slot waits to drain.
module issue_buf_entry
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  alu_issue_t        wr_data,
   input  logic              flush_valid,
   input  logic [WFID_W-1:0] flush_wfid,
   output alu_issue_t        data,
   output logic              live
);

   alu_issue_t data_r;
   logic       live_r;

   // A write landing together with a flush of its own wavefront is stored already squashed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_r <= '0;
         live_r <= 1'b0;
      end else if (wr_en) begin
         data_r <= wr_data;
         live_r <= !wfid_match(flush_valid, flush_wfid, wr_data.wfid);
      end else if (wfid_match(flush_valid, flush_wfid, data_r.wfid)) begin
         live_r <= 1'b0;
      end else begin
         live_r <= live_r;
      end
   end

   assign data = data_r;
   assign live = live_r;

endmodule

// File: rtl/issue_alu_pipe_buffer.sv
// In-order DEPTH-entry buffer between issue and one ALU with valid/ready
// handshake and per-wavefront flush; squashed entries drain without reaching the ALU.
module issue_alu_pipe_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                    clk,
   input  logic                    rst,
   issue_alu_pipe_buffer_if.slave  bus,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("issue_alu_pipe_buffer: DEPTH must be a power of 2 and >= 2");
   end

   alu_issue_t       in_data_s;
   alu_issue_t       head_s;
   alu_issue_t       entry_data_s [DEPTH];
   logic [DEPTH-1:0] entry_live_s;
   logic             head_live_s;
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic             occupied_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             push_s;
   logic             pop_s;

   // Bundle the issue-side fields into one entry word.
   always_comb begin
      in_data_s              = '0;
      in_data_s.wfid         = bus.in_wfid;
      in_data_s.instr_pc     = bus.in_instr_pc;
      in_data_s.opcode       = bus.in_opcode;
      in_data_s.imm_value0   = bus.in_imm_value0;
      in_data_s.imm_value1   = bus.in_imm_value1;
      in_data_s.source1_addr = bus.in_source1_addr;
      in_data_s.source2_addr = bus.in_source2_addr;
      in_data_s.source3_addr = bus.in_source3_addr;
      in_data_s.dest1_addr   = bus.in_dest1_addr;
      in_data_s.dest2_addr   = bus.in_dest2_addr;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      issue_buf_entry u_entry (
         .clk         (clk),
         .rst         (rst),
         .wr_en       (push_s && (tail_r == PTR_W'(i))),
         .wr_data     (in_data_s),
         .flush_valid (bus.flush_valid),
         .flush_wfid  (bus.flush_wfid),
         .data        (entry_data_s[i]),
         .live        (entry_live_s[i])
      );
   end

   // Handshake decode; a head being flushed this cycle is hidden so it cannot be accepted.
   always_comb begin
      head_s      = entry_data_s[head_r];
      head_live_s = entry_live_s[head_r];
      occupied_s  = (count_r != {CNT_W{1'b0}});
      in_ready_s  = (count_r < CNT_W'(DEPTH));
      out_valid_s = occupied_s && head_live_s &&
                    !wfid_match(bus.flush_valid, bus.flush_wfid, head_s.wfid);
      push_s      = bus.in_valid && in_ready_s;
      pop_s       = occupied_s && ((out_valid_s && bus.out_ready) || !head_live_s);
   end

   // Pointers wrap naturally; full/empty comes from the occupancy count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end else begin
            tail_r <= tail_r;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end else begin
            head_r <= head_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign bus.in_ready         = in_ready_s;
   assign bus.out_valid        = out_valid_s;
   assign bus.out_wfid         = head_s.wfid;
   assign bus.out_instr_pc     = head_s.instr_pc;
   assign bus.out_opcode       = head_s.opcode;
   assign bus.out_imm_value0   = head_s.imm_value0;
   assign bus.out_imm_value1   = head_s.imm_value1;
   assign bus.out_source1_addr = head_s.source1_addr;
   assign bus.out_source2_addr = head_s.source2_addr;
   assign bus.out_source3_addr = head_s.source3_addr;
   assign bus.out_dest1_addr   = head_s.dest1_addr;
   assign bus.out_dest2_addr   = head_s.dest2_addr;
   assign count                = count_r;

endmodule

// File: tb/tb_issue_alu_pipe_buffer.sv
// Scoreboard bench for issue_alu_pipe_buffer (DEPTH=4): directed scenarios then random traffic.
module tb_issue_alu_pipe_buffer;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CNT_W-1:0] count;

   issue_alu_pipe_buffer_if bus();

   issue_alu_pipe_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      alu_issue_t d;
      bit         live;
   } rec_t;

   rec_t mq[$];     // occupancy model, including squashed entries awaiting drain
   rec_t exp_q[$];  // scoreboard of pushed instructions in order
   int   checks = 0;
   int   failures = 0;
   int   delivered = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic alu_issue_t mk(input int wfid, input int pc);
      alu_issue_t d;
      d.wfid         = WFID_W'(wfid);
      d.instr_pc     = PC_W'(pc);
      d.opcode       = OPC_W'($urandom);
      d.imm_value0   = IMM0_W'($urandom);
      d.imm_value1   = IMM1_W'($urandom);
      d.source1_addr = ADDR_W'($urandom);
      d.source2_addr = ADDR_W'($urandom);
      d.source3_addr = ADDR_W'($urandom);
      d.dest1_addr   = ADDR_W'($urandom);
      d.dest2_addr   = ADDR_W'($urandom);
      return d;
   endfunction

   function automatic alu_issue_t head_out();
      alu_issue_t d;
      d.wfid         = bus.out_wfid;
      d.instr_pc     = bus.out_instr_pc;
      d.opcode       = bus.out_opcode;
      d.imm_value0   = bus.out_imm_value0;
      d.imm_value1   = bus.out_imm_value1;
      d.source1_addr = bus.out_source1_addr;
      d.source2_addr = bus.out_source2_addr;
      d.source3_addr = bus.out_source3_addr;
      d.dest1_addr   = bus.out_dest1_addr;
      d.dest2_addr   = bus.out_dest2_addr;
      return d;
   endfunction

   task automatic drive_in(input alu_issue_t d);
      bus.in_wfid         = d.wfid;
      bus.in_instr_pc     = d.instr_pc;
      bus.in_opcode       = d.opcode;
      bus.in_imm_value0   = d.imm_value0;
      bus.in_imm_value1   = d.imm_value1;
      bus.in_source1_addr = d.source1_addr;
      bus.in_source2_addr = d.source2_addr;
      bus.in_source3_addr = d.source3_addr;
      bus.in_dest1_addr   = d.dest1_addr;
      bus.in_dest2_addr   = d.dest2_addr;
   endtask

   // One clock cycle of stimulus; the model advances with the edge that follows.
   task automatic cycle(input bit iv, input alu_issue_t d, input bit ordy,
                        input bit fv, input int fw);
      bit   m_ready;
      bit   m_ov;
      rec_t r;
      @(negedge clk);
      bus.in_valid    = iv;
      drive_in(d);
      bus.out_ready   = ordy;
      bus.flush_valid = fv;
      bus.flush_wfid  = WFID_W'(fw);
      #1;
      m_ready = (mq.size() < DEPTH);
      m_ov    = (mq.size() != 0) && mq[0].live && !(fv && (WFID_W'(fw) == mq[0].d.wfid));
      check("in_ready", bus.in_ready, m_ready);
      check("count", count, mq.size());
      check("out_valid", bus.out_valid, m_ov);
      if (mq.size() != 0 && ((m_ov && ordy) || !mq[0].live)) void'(mq.pop_front());
      if (fv) begin
         foreach (mq[i])    if (mq[i].d.wfid == WFID_W'(fw)) mq[i].live = 1'b0;
         foreach (exp_q[i]) if (exp_q[i].d.wfid == WFID_W'(fw)) exp_q[i].live = 1'b0;
      end
      #2;
      if (iv && m_ready) begin
         r.d    = d;
         r.live = !(fv && (WFID_W'(fw) == d.wfid));
         mq.push_back(r);
         exp_q.push_back(r);
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0), ordy, 1'b0, 0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst          = 1'b0;
         bus.in_valid = 1'b1;
         drive_in(mk(63, 32'hdead));
         bus.out_ready   = 1'b0;
         bus.flush_valid = 1'b0;
      end
      mq.delete();
      exp_q.delete();
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_fields", head_out(), 0);
   endtask

   // Monitor: every accepted head must be the oldest still-live scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            while (exp_q.size() != 0 && !exp_q[0].live) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL deliver_unexpected actual_wfid=%0h required=none", bus.out_wfid);
            end else begin
               check("deliver", head_out(), exp_q[0].d);
               void'(exp_q.pop_front());
               delivered++;
            end
         end
      end
   end

   initial begin
      int live_left;
      bus.in_valid    = 1'b1;
      bus.out_ready   = 1'b0;
      bus.flush_valid = 1'b0;
      bus.flush_wfid  = '0;
      drive_in(mk(1, 1));
      do_reset(2);

      // back-to-back with a ready ALU
      cycle(1'b1, mk(1, 32'h100), 1'b1, 1'b0, 0);
      cycle(1'b1, mk(2, 32'h104), 1'b1, 1'b0, 0);
      cycle(1'b1, mk(3, 32'h108), 1'b1, 1'b0, 0);
      idle(3, 1'b1);

      // backpressure: fill, attempt a fifth push, then drain
      for (int i = 0; i < 4; i++) cycle(1'b1, mk(10 + i, 32'h200 + 4 * i), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(14, 32'h210), 1'b0, 1'b0, 0);
      idle(6, 1'b1);

      // flush mid-queue
      cycle(1'b1, mk(5, 32'h300), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(7, 32'h304), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(5, 32'h308), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(9, 32'h30c), 1'b0, 1'b0, 0);
      cycle(1'b0, mk(0, 0), 1'b1, 1'b1, 5);
      idle(5, 1'b1);

      // flush on head with a simultaneous push of the same wavefront
      cycle(1'b1, mk(3, 32'h400), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(3, 32'h404), 1'b1, 1'b1, 3);
      cycle(1'b1, mk(4, 32'h408), 1'b1, 1'b0, 0);
      idle(5, 1'b1);

      // push/pop pairs across the pointer wrap, then reset with entries held
      for (int i = 0; i < 10; i++) cycle(1'b1, mk(20 + i, 32'h500 + 4 * i), 1'b1, 1'b0, 0);
      idle(3, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(40 + i, 32'h600 + 4 * i), 1'b0, 1'b0, 0);
      cycle(1'b0, mk(0, 0), 1'b0, 1'b0, 0);
      do_reset(1);

      // random traffic with frequent flush hits
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 9) < 7, mk($urandom_range(0, 3), $urandom),
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, $urandom_range(0, 3));
      end
      idle(10, 1'b1);

      live_left = 0;
      foreach (exp_q[i]) if (exp_q[i].live) live_left++;
      check("drain_live_left", live_left, 0);
      check("drain_count", count, 0);
      checks++;
      if (delivered < 50) begin
         failures++;
         $display("FAIL delivered_total actual=%0d required>=50", delivered);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
